riscv_divider: RTL and testbench

Parametrised iterative integer divider for the execute stage: the successor to `division_wrapper`. It implements all four RV32M/RV64M divide operations (DIV, DIVU, REM, REMU) with the ISA-mandated results for divide-by-zero and signed overflow. Width and radix (quotient bits retired per cycle) are parameters. It supports an abort input so the pipeline can flush an in-flight divide.

---
 rtl/riscv_divider.sv | 176 +++++++++++++++++
 tb/tb_riscv_divider.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_divider.sv
// Iterative RV32M/RV64M divider (DIV, DIVU, REM, REMU) retiring BITS_PER_CYCLE quotient bits/cycle.
// Build macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and divisor=1 bypass the ITER phase.
module riscv_divider #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] result,
  output logic             divide_by_zero,
  output logic             overflow
);

  localparam int unsigned N        = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PrW      = WIDTH + BITS_PER_CYCLE;
  localparam int unsigned NumTrial = (1 << BITS_PER_CYCLE) - 1;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  rem_sel_q;
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      dvs_q;
  logic [WIDTH-1:0]      dvd_q;
  logic [WIDTH-1:0]      rem_q;
  logic                  q_neg_q, r_neg_q;
  logic                  div0_q, ovf_q, one_q;
  logic                  done_q;
  logic [WIDTH-1:0]      quotient_q, remainder_q, result_q;
  logic                  dz_q, ov_q;

  // Operand decode at accept time.
  logic                  is_signed_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0]      a_mag_in, b_mag_in;
  logic                  div0_in, ovf_in, one_in;

  assign is_signed_in = ~op[0];
  assign a_neg_in     = is_signed_in & dividend[WIDTH-1];
  assign b_neg_in     = is_signed_in & divisor[WIDTH-1];
  assign a_mag_in     = a_neg_in ? (~dividend + WIDTH'(1)) : dividend;
  assign b_mag_in     = b_neg_in ? (~divisor + WIDTH'(1)) : divisor;
  assign div0_in      = (divisor == '0);
  assign ovf_in       = is_signed_in & (dividend == MinVal) & (&divisor);
  assign one_in       = (divisor == WIDTH'(1));

  // One restoring step: pick the largest digit k with k*divisor <= partial remainder.
  logic [PrW-1:0]            pr, mult;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [WIDTH-1:0]          rem_next;

  always_comb begin
    pr       = {rem_q, dvd_q[WIDTH-1 -: BITS_PER_CYCLE]};
    mult     = '0;
    digit    = '0;
    rem_next = pr[WIDTH-1:0];
    for (int unsigned k = 1; k <= NumTrial; k++) begin
      mult = mult + {{BITS_PER_CYCLE{1'b0}}, dvs_q};
      if (pr >= mult) begin
        digit    = BITS_PER_CYCLE'(k);
        rem_next = WIDTH'(pr - mult);
      end
    end
  end

  // Sign correction and special-case override applied in FIX.
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    q_fix = q_neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
    r_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
    if (div0_q) begin
      q_fix = '1;
      r_fix = a_q;
    end else if (ovf_q) begin
      q_fix = MinVal;
      r_fix = '0;
    end else if (one_q) begin
      q_fix = a_q;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_sel_q   <= 1'b0;
      a_q         <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      one_q       <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      result_q    <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // kill is meaningless here, so a simultaneous start still wins.
          if (start) begin
            rem_sel_q <= op[1];
            a_q       <= dividend;
            dvd_q     <= a_mag_in;
            dvs_q     <= b_mag_in;
            rem_q     <= '0;
            q_neg_q   <= a_neg_in ^ b_neg_in;
            r_neg_q   <= a_neg_in;
            div0_q    <= div0_in;
            ovf_q     <= ovf_in;
            one_q     <= one_in;
            cnt_q     <= CntW'(N - 1);
`ifdef DIV_EARLY_OUT_EN
            state_q   <= (div0_in | ovf_in | one_in) ? StFix : StIter;
`else
            state_q   <= StIter;
`endif
          end
        end
        StIter: begin
          if (kill) begin
            state_q <= StIdle;
          end else begin
            dvd_q <= {dvd_q[WIDTH-BITS_PER_CYCLE-1:0], digit};
            rem_q <= rem_next;
            if (cnt_q == '0) begin
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        StFix: begin
          state_q <= StIdle;
          if (!kill) begin
            done_q      <= 1'b1;
            quotient_q  <= q_fix;
            remainder_q <= r_fix;
            result_q    <= rem_sel_q ? r_fix : q_fix;
            dz_q        <= div0_q;
            ov_q        <= ovf_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign quotient       = quotient_q;
  assign remainder      = remainder_q;
  assign result         = result_q;
  assign divide_by_zero = dz_q;
  assign overflow       = ov_q;

endmodule

// File: tb/tb_riscv_divider.sv
// Scoreboard bench for riscv_divider: a 1-bit/cycle and a 4-bit/cycle instance, both 32 bits wide.
// Expected latency follows the DIV_EARLY_OUT_EN build macro when it is defined.
module tb_riscv_divider;

  localparam int unsigned W  = 32;
  localparam int unsigned N1 = 32;
  localparam int unsigned N4 = 8;
`ifdef DIV_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif
  localparam logic [W-1:0] MinVal = 32'h8000_0000;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] res;
    logic         dz;
    logic         ov;
  } exp_t;

  logic         clk_tb = 1'b0;
  logic         reset_n, start, kill;
  logic [1:0]   op;
  logic [W-1:0] dividend, divisor;
  int           sel = 0;

  logic         start1, start4;
  logic         busy1, done1, dz1, ov1, busy4, done4, dz4, ov4;
  logic [W-1:0] q1, r1, res1, q4, r4, res4;
  logic         o_busy, o_done;
  exp_t         obs;

  exp_t sb_q[$];
  exp_t e, last_exp;
  int   total = 0;
  int   bad = 0;

  always #5 clk_tb = ~clk_tb;

  assign start1 = start & (sel == 0);
  assign start4 = start & (sel == 1);

  riscv_divider #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk_tb), .reset(reset_n), .start(start1), .op(op), .dividend(dividend),
    .divisor(divisor), .kill(kill), .busy(busy1), .done(done1), .quotient(q1),
    .remainder(r1), .result(res1), .divide_by_zero(dz1), .overflow(ov1)
  );

  riscv_divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk_tb), .reset(reset_n), .start(start4), .op(op), .dividend(dividend),
    .divisor(divisor), .kill(kill), .busy(busy4), .done(done4), .quotient(q4),
    .remainder(r4), .result(res4), .divide_by_zero(dz4), .overflow(ov4)
  );

  always_comb begin
    if (sel == 1) begin
      o_busy = busy4;
      o_done = done4;
      obs    = {q4, r4, res4, dz4, ov4};
    end else begin
      o_busy = busy1;
      o_done = done1;
      obs    = {q1, r1, res1, dz1, ov1};
    end
  end

  // Reference: RISC-V M-extension semantics, computed with 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   x;
    longint sa, sb;
    x = '0;
    if (b == '0) begin
      x.q  = '1;
      x.r  = a;
      x.dz = 1'b1;
    end else if (!o[0] && a == MinVal && b == 32'hFFFF_FFFF) begin
      x.q  = MinVal;
      x.r  = '0;
      x.ov = 1'b1;
    end else if (o[0]) begin
      x.q = a / b;
      x.r = a % b;
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      x.q = 32'(sa / sb);
      x.r = 32'(sa % sb);
    end
    x.res = o[1] ? x.r : x.q;
    return x;
  endfunction

  // Edges from the accept edge to the edge that raises done.
  function automatic int exp_edges(input int s, input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    bit special;
    special = (b == '0) || (b == 32'd1) || (!o[0] && a == MinVal && b == 32'hFFFF_FFFF);
    if (Early && special) return 1;
    return (s == 1) ? int'(N4) + 1 : int'(N1) + 1;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk_tb);
    #1;
    start = 1'b0;
    if (push) sb_q.push_back(model(o, a, b));
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = o_busy ? 1 : 0;
    while (!o_done && edges < 200) begin
      @(posedge clk_tb);
      #1;
      edges++;
      if (o_busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", s, obs);
      end
      total++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy_done dut%0d: got busy=%b done=%b want 0/0", s, o_busy, o_done);
      end
    end
  endtask

  task automatic test_signed_div();
    int edges, bcnt;
    sel = 0;
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(edges, bcnt);
    e = sb_q.pop_front();
    last_exp = e;
    total++;
    if (edges !== int'(N1) + 1) begin
      bad++;
      $display("FAIL div_latency: got %0d edges want %0d", edges, N1 + 1);
    end
    total++;
    if (bcnt !== int'(N1) + 1) begin
      bad++;
      $display("FAIL div_busy_cycles: got %0d want %0d", bcnt, N1 + 1);
    end
    total++;
    if (obs.q !== 32'hFFFF_FFFD || obs.r !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div_neg7_2: got q=%h r=%h want fffffffd/ffffffff", obs.q, obs.r);
    end
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL div_scoreboard: got %h want %h", obs, e);
    end
    @(posedge clk_tb);
    #1;
    total++;
    if (o_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got done=%b want 0", o_done);
    end
  endtask

  task automatic test_unsigned();
    int edges, bcnt;
    sel = 0;
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done(edges, bcnt);
    e = sb_q.pop_front();
    total++;
    if (obs.q !== 32'h7FFF_FFFF || obs.r !== 32'd1 || obs.res !== 32'h7FFF_FFFF) begin
      bad++;
      $display("FAIL divu: got q=%h r=%h res=%h want 7fffffff/1/7fffffff", obs.q, obs.r, obs.res);
    end
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL divu_scoreboard: got %h want %h", obs, e);
    end
    issue(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done(edges, bcnt);
    e = sb_q.pop_front();
    last_exp = e;
    total++;
    if (obs.res !== 32'd1 || obs !== e) begin
      bad++;
      $display("FAIL remu: got %h want %h", obs, e);
    end
  endtask

  task automatic test_div_zero();
    int edges, bcnt;
    sel = 0;
    issue(2'b00, 32'd5, 32'd0, 1'b1);
    wait_done(edges, bcnt);
    e = sb_q.pop_front();
    last_exp = e;
    total++;
    if (edges !== exp_edges(0, 2'b00, 32'd5, 32'd0)) begin
      bad++;
      $display("FAIL div0_latency: got %0d want %0d", edges, exp_edges(0, 2'b00, 32'd5, 32'd0));
    end
    total++;
    if (obs.q !== 32'hFFFF_FFFF || obs.r !== 32'd5 || obs.dz !== 1'b1 || obs.ov !== 1'b0) begin
      bad++;
      $display("FAIL div0: got %h want %h", obs, e);
    end
  endtask

  task automatic test_overflow();
    int edges, bcnt;
    sel = 0;
    issue(2'b10, MinVal, 32'hFFFF_FFFF, 1'b1);
    wait_done(edges, bcnt);
    e = sb_q.pop_front();
    last_exp = e;
    total++;
    if (obs.q !== MinVal || obs.r !== 32'd0 || obs.ov !== 1'b1 || obs.res !== 32'd0) begin
      bad++;
      $display("FAIL overflow: got %h want %h", obs, e);
    end
    total++;
    if (edges !== exp_edges(0, 2'b10, MinVal, 32'hFFFF_FFFF)) begin
      bad++;
      $display("FAIL ovf_latency: got %0d want %0d", edges,
               exp_edges(0, 2'b10, MinVal, 32'hFFFF_FFFF));
    end
  endtask

  task automatic test_ignore_start();
    int edges, bcnt, extra;
    sel = 0;
    issue(2'b00, 32'd100, 32'd7, 1'b1);
    repeat (4) @(posedge clk_tb);
    #1;
    issue(2'b01, 32'd9, 32'd3, 1'b0);
    wait_done(edges, bcnt);
    e = sb_q.pop_front();
    last_exp = e;
    total++;
    if (o_done !== 1'b1 || obs !== e) begin
      bad++;
      $display("FAIL ignore_start: got done=%b %h want %h", o_done, obs, e);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_tb);
      #1;
      if (o_done || o_busy) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL no_queued_start: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_kill();
    int edges, bcnt, dones;
    sel = 0;
    issue(2'b00, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk_tb);
    #1;
    kill = 1'b1;
    @(posedge clk_tb);
    #1;
    kill = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL kill_idle: got busy=%b done=%b want 0/0", o_busy, o_done);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_tb);
      #1;
      if (o_done) dones++;
    end
    total++;
    if (dones !== 0 || obs !== last_exp) begin
      bad++;
      $display("FAIL kill_outputs: got dones=%0d %h want 0 %h", dones, obs, last_exp);
    end
    // kill together with start in IDLE: start wins.
    kill = 1'b1;
    issue(2'b00, 32'd1000, 32'd3, 1'b1);
    kill = 1'b0;
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL kill_start_accept: got busy=%b want 1", o_busy);
    end
    wait_done(edges, bcnt);
    e = sb_q.pop_front();
    last_exp = e;
    total++;
    if (edges !== int'(N1) + 1 || obs !== e) begin
      bad++;
      $display("FAIL kill_start_result: got %0d edges %h want %0d %h", edges, obs, N1 + 1, e);
    end
  endtask

  task automatic test_radix4();
    int edges, bcnt, want;
    logic [1:0]   o;
    logic [W-1:0] a, b;
    sel = 1;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 6))
        0: b = '0;
        1: b = 32'd1;
        2: begin
          a = MinVal;
          b = 32'hFFFF_FFFF;
        end
        3: b = 32'($urandom_range(1, 15));
        4: b = ~32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      want = exp_edges(1, o, a, b);
      // Issued straight from the previous done cycle, so this also exercises back-to-back.
      issue(o, a, b, 1'b1);
      total++;
      if (o_busy !== 1'b1) begin
        bad++;
        $display("FAIL b2b_accept[%0d]: got busy=%b want 1", i, o_busy);
      end
      wait_done(edges, bcnt);
      e = sb_q.pop_front();
      total++;
      if (edges !== want) begin
        bad++;
        $display("FAIL r4_latency[%0d]: got %0d want %0d", i, edges, want);
      end
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL r4_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    issue(2'b00, 32'd1234, 32'd5, 1'b0);
    repeat (5) @(posedge clk_tb);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got %h busy=%b done=%b want 0", obs, o_busy, o_done);
    end
    @(negedge clk_tb);
    reset_n = 1'b1;
    @(posedge clk_tb);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    kill     = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    last_exp = '0;
    repeat (3) @(negedge clk_tb);
    reset_n = 1'b1;
    @(posedge clk_tb);
    #1;
    test_reset();
    test_signed_div();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_kill();
    test_radix4();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
